gmii_tx_framer: RTL and testbench

//  MAC-side GMII transmit framer. Takes a byte-wide AXI-Stream frame (dest MAC onward, no FCS)
//  and drives GMII_TX_EN/ER/TXD into the RGMII I/O block. Framing: 7x preamble, SFD, data,

---
 rtl/gmii_tx_framer_if.sv | 12 +
 rtl/gmii_tx_framer.sv | 144 ++++++++++++++
 tb/tb_gmii_tx_framer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gmii_tx_framer_if.sv
// Byte-wide AXI-Stream frame input of the GMII transmit framer.
// The source drives data/valid/last/user; the framer returns ready.
interface gmii_tx_framer_if;
  logic [7:0] S_TDATA;
  logic       S_TVALID;
  logic       S_TLAST;
  logic       S_TUSER;
  logic       S_TREADY;

  modport master (output S_TDATA, S_TVALID, S_TLAST, S_TUSER, input S_TREADY);
  modport slave  (input S_TDATA, S_TVALID, S_TLAST, S_TUSER, output S_TREADY);
endinterface

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble, SFD, payload, zero pad, CRC-32 FCS and inter-frame gap.
// GMII outputs are registered, so each byte appears one cycle after the state that produces it.
module gmii_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_BYTES    = 12
) (
  input  logic            GMII_TX_CLK,
  input  logic            SYNC_RST,
  gmii_tx_framer_if.slave s_axis,
  output logic            GMII_TX_EN,
  output logic            GMII_TX_ER,
  output logic [7:0]      GMII_TXD,
  output logic            TX_BUSY,
  output logic            FRAME_DONE,
  output logic            FRAME_ABORT
);
  localparam int          CNT_W    = 8;
  localparam int          BC_W     = $clog2(MIN_FRAME + 1);
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG, DROP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d, byte_cnt_inc;
  logic [31:0]       crc_q, crc_d, crc_inv;
  logic              tx_en_q, tx_en_d, tx_er_q, tx_er_d;
  logic              done_q, done_d, abort_q, abort_d;
  logic [7:0]        txd_q, txd_d;
  logic              beat_bad, pad_done;

  function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    return c;
  endfunction

  // In DATA a missing beat (underrun) and an accepted errored beat both abort the frame.
  assign beat_bad     = !s_axis.S_TVALID || s_axis.S_TUSER;
  assign pad_done     = (int'(byte_cnt_q) + 1 >= MIN_FRAME);
  assign byte_cnt_inc = (byte_cnt_q == BC_W'(MIN_FRAME)) ? byte_cnt_q : byte_cnt_q + BC_W'(1);
  assign crc_inv      = ~crc_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge GMII_TX_CLK) begin
    if (SYNC_RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      byte_cnt_q <= '0;
      crc_q      <= CRC_INIT;
      tx_en_q    <= 1'b0;
      tx_er_q    <= 1'b0;
      txd_q      <= 8'h00;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      crc_q      <= crc_d;
      tx_en_q    <= tx_en_d;
      tx_er_q    <= tx_er_d;
      txd_q      <= txd_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (s_axis.S_TVALID) state_d = PREAMBLE;
      PREAMBLE: if (cnt_q == CNT_W'(PREAMBLE_LEN - 1)) state_d = SFD;
      SFD:      state_d = DATA;
      DATA: begin
        if (beat_bad)             state_d = (s_axis.S_TVALID && s_axis.S_TLAST) ? IFG : DROP;
        else if (s_axis.S_TLAST)  state_d = pad_done ? FCS : PAD;
      end
      PAD:      if (pad_done) state_d = FCS;
      FCS:      if (cnt_q == CNT_W'(3)) state_d = IFG;
      // A frame already waiting starts straight away so the gap stays exactly IFG_BYTES.
      IFG:      if (cnt_q == CNT_W'(IFG_BYTES - 1)) state_d = s_axis.S_TVALID ? PREAMBLE : IDLE;
      DROP:     if (s_axis.S_TVALID && s_axis.S_TLAST) state_d = IFG;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
    crc_d      = crc_q;
    byte_cnt_d = byte_cnt_q;
    tx_en_d    = 1'b0;
    tx_er_d    = 1'b0;
    txd_d      = 8'h00;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    case (state_q)
      PREAMBLE: begin
        tx_en_d = 1'b1;
        txd_d   = 8'h55;
      end
      SFD: begin
        tx_en_d    = 1'b1;
        txd_d      = 8'hD5;
        crc_d      = CRC_INIT;
        byte_cnt_d = '0;
      end
      DATA: begin
        tx_en_d = 1'b1;
        if (beat_bad) begin
          tx_er_d = 1'b1;
          abort_d = 1'b1;
        end else begin
          txd_d      = s_axis.S_TDATA;
          crc_d      = crc_next(crc_q, s_axis.S_TDATA);
          byte_cnt_d = byte_cnt_inc;
        end
      end
      PAD: begin
        tx_en_d    = 1'b1;
        crc_d      = crc_next(crc_q, 8'h00);
        byte_cnt_d = byte_cnt_inc;
      end
      FCS: begin
        tx_en_d = 1'b1;
        txd_d   = crc_inv[{cnt_q[1:0], 3'b000} +: 8];
        done_d  = (cnt_q == CNT_W'(3));
      end
      default: ;
    endcase
  end

  assign s_axis.S_TREADY = (state_q == DATA) || (state_q == DROP);
  assign TX_BUSY         = (state_q != IDLE);
  assign GMII_TX_EN      = tx_en_q;
  assign GMII_TX_ER      = tx_er_q;
  assign GMII_TXD        = txd_q;
  assign FRAME_DONE      = done_q;
  assign FRAME_ABORT     = abort_q;
endmodule

// File: tb/tb_gmii_tx_framer.sv
// Scoreboard bench for gmii_tx_framer: stimulus pushes the expected GMII byte stream,
// a forked monitor pops and compares whenever TX_EN is high.
module tb_gmii_tx_framer;
  localparam int PREAMBLE_LEN = 7;
  localparam int MIN_FRAME    = 60;
  localparam int IFG_BYTES    = 12;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] txd;
    logic       er;
    logic       done;
    logic       abort;
    logic       last;
    int         gap;   // first byte only: exact idle run before it, or -1 for "at least IFG_BYTES"
  } item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_en, tx_er, busy, done, abort;
  logic [7:0] txd;

  gmii_tx_framer_if s_if ();

  gmii_tx_framer #(
    .PREAMBLE_LEN (PREAMBLE_LEN),
    .MIN_FRAME    (MIN_FRAME),
    .IFG_BYTES    (IFG_BYTES)
  ) dut (
    .GMII_TX_CLK (clk),
    .SYNC_RST    (rst),
    .s_axis      (s_if),
    .GMII_TX_EN  (tx_en),
    .GMII_TX_ER  (tx_er),
    .GMII_TXD    (txd),
    .TX_BUSY     (busy),
    .FRAME_DONE  (done),
    .FRAME_ABORT (abort)
  );

  always #4 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  item_t       exp_q[$];
  logic [31:0] crc_tab[256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Table-driven reflected CRC-32 (no final inversion).
  function automatic logic [31:0] crc_upd(input logic [31:0] crc, input bq_t bytes);
    logic [31:0] c;
    c = crc;
    foreach (bytes[i]) c = (c >> 8) ^ crc_tab[c[7:0] ^ bytes[i]];
    return c;
  endfunction

  task automatic push(input logic [7:0] d, input logic er, input logic dn, input logic ab,
                      input logic last, input int gap);
    item_t it;
    it.txd = d; it.er = er; it.done = dn; it.abort = ab; it.last = last; it.gap = gap;
    exp_q.push_back(it);
  endtask

  // Reference model: the wire image of one frame, built from the framing rules.
  task automatic expect_frame(input bq_t data, input int abort_at, input int fcs_keep, input int gap);
    bq_t         body;
    logic [31:0] fcs;
    for (int i = 0; i < PREAMBLE_LEN; i++) push(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, (i == 0) ? gap : -1);
    push(8'hD5, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    if (abort_at >= 0) begin
      for (int i = 0; i < abort_at; i++) push(data[i], 1'b0, 1'b0, 1'b0, 1'b0, -1);
      push(8'h00, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    end else begin
      body = data;
      while (body.size() < MIN_FRAME) body.push_back(8'h00);
      foreach (body[i]) push(body[i], 1'b0, 1'b0, 1'b0, 1'b0, -1);
      fcs = ~crc_upd(32'hFFFFFFFF, body);
      for (int i = 0; i < fcs_keep; i++)
        push(fcs[8*i +: 8], 1'b0, i == 3, 1'b0, i == fcs_keep - 1, -1);
    end
  endtask

  task automatic send_frame(input bq_t data, input int underrun_at, input int tuser_at,
                            input int fcs_keep, input int gap);
    int   abort_at;
    int   accepted;
    int   n;
    logic ok;
    abort_at = (underrun_at >= 0) ? underrun_at : tuser_at;
    accepted = 0;
    expect_frame(data, abort_at, fcs_keep, gap);
    for (int i = 0; i < data.size(); i++) begin
      if (i == underrun_at) begin
        s_if.S_TVALID = 1'b0;
        @(posedge clk); #1;
      end
      s_if.S_TVALID = 1'b1;
      s_if.S_TDATA  = data[i];
      s_if.S_TLAST  = (i == data.size() - 1);
      s_if.S_TUSER  = (i == tuser_at);
      n = 0;
      do begin
        ok = s_if.S_TREADY;
        @(posedge clk); #1;
        n++;
      end while (!ok && n < 300);
      if (!ok) break;
      accepted++;
    end
    s_if.S_TVALID = 1'b0;
    s_if.S_TLAST  = 1'b0;
    s_if.S_TUSER  = 1'b0;
    check("frame_beats_accepted", 64'(accepted), 64'(data.size()));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    int    idle_run;
    int    pos;
    logic  in_burst;
    logic  prev_last;
    bq_t   rx;
    item_t it;
    idle_run = 0; pos = 0; in_burst = 1'b0; prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_en) begin
        if (!in_burst) begin
          pos = 0;
          rx  = {};
        end
        if (exp_q.size() == 0) begin
          check("unexpected_tx_en", 64'(tx_en), 64'd0);
        end else begin
          it = exp_q.pop_front();
          if (!in_burst) begin
            if (it.gap >= 0) check("ifg_exact", 64'(idle_run), 64'(it.gap));
            else             check("ifg_min", 64'(idle_run >= IFG_BYTES), 64'd1);
          end
          check("txd", 64'(txd), 64'(it.txd));
          check("er_done_abort", 64'({tx_er, done, abort}), 64'({it.er, it.done, it.abort}));
          if (pos >= PREAMBLE_LEN + 1) rx.push_back(txd);
          if (it.done) check("rx_residue", 64'(crc_upd(32'hFFFFFFFF, rx)), 64'h0DEBB20E3);
          prev_last = it.last;
        end
        pos++;
        in_burst = 1'b1;
        idle_run = 0;
      end else begin
        if (in_burst) check("burst_end", 64'(prev_last), 64'd1);
        check("idle_quiet", 64'({tx_er, done, abort}), 64'd0);
        in_burst = 1'b0;
        idle_run++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t         d, d2;
    logic [31:0] c;
    int          n, len, mode, ua, ta;

    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[i] = c;
    end

    rst = 1'b1;
    s_if.S_TDATA = 8'h00; s_if.S_TVALID = 1'b0; s_if.S_TLAST = 1'b0; s_if.S_TUSER = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gmii", 64'({tx_en, tx_er, txd}), 64'd0);
    check("rst_status", 64'({busy, done, abort, s_if.S_TREADY}), 64'd0);
    rst = 1'b0;

    fork
      monitor();
    join_none
    repeat (20) @(posedge clk);
    #1;

    // Minimum-length frame, counting pattern.
    d = {};
    for (int i = 0; i < 60; i++) d.push_back(8'(i));
    send_frame(d, -1, -1, 4, -1);
    wait_idle();

    // Short frame that needs zero padding.
    d = {};
    for (int i = 0; i < 14; i++) d.push_back(8'($urandom));
    send_frame(d, -1, -1, 4, -1);
    wait_idle();

    // Back-to-back frames: gap must be exactly IFG_BYTES.
    d = {}; d2 = {};
    for (int i = 0; i < 64; i++) begin
      d.push_back(8'($urandom));
      d2.push_back(8'($urandom));
    end
    send_frame(d, -1, -1, 4, -1);
    send_frame(d2, -1, -1, 4, IFG_BYTES);
    wait_idle();

    // Underrun at byte 20 of 100: remainder dropped, then IFG before IDLE.
    d = {};
    for (int i = 0; i < 100; i++) d.push_back(8'($urandom));
    send_frame(d, 20, -1, 4, -1);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check("drop_ifg_busy_cycles", 64'(n), 64'(IFG_BYTES));
    wait_idle();

    // Reset while the second FCS byte is on the wire.
    d = {};
    for (int i = 0; i < 60; i++) d.push_back(8'($urandom));
    send_frame(d, -1, -1, 2, -1);
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    rst = 1'b1;
    @(negedge clk); #1;
    check("mid_fcs_rst_gmii", 64'({tx_en, tx_er, txd}), 64'd0);
    check("mid_fcs_rst_status", 64'({busy, s_if.S_TREADY}), 64'd0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    send_frame(d, -1, -1, 4, -1);
    wait_idle();

    // Error on the TLAST beat: no FCS, IFG follows directly.
    d = {}; d2 = {};
    for (int i = 0; i < 70; i++) d.push_back(8'($urandom));
    for (int i = 0; i < 30; i++) d2.push_back(8'($urandom));
    send_frame(d, -1, 69, 4, -1);
    send_frame(d2, -1, -1, 4, IFG_BYTES);
    wait_idle();

    // Randomized frames with occasional underrun or errored beat.
    for (int f = 0; f < 25; f++) begin
      len  = $urandom_range(100, 1);
      mode = $urandom_range(9, 0);
      ua   = -1;
      ta   = -1;
      d    = {};
      for (int i = 0; i < len; i++) d.push_back(8'($urandom));
      if (mode == 0 && len >= 2) ua = $urandom_range(len - 1, 1);
      else if (mode == 1)        ta = $urandom_range(len - 1, 0);
      send_frame(d, ua, ta, 4, -1);
      n = $urandom_range(15, 0);
      if (n > 0) begin
        repeat (n) @(posedge clk);
        #1;
      end
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
